decode_issue: RTL and testbench

- Front end of the integer pipe.
- Accepts raw 32-bit instructions from fetch over a valid/ready handshake, decodes them into the field bundle consumed by the integer execution unit, and reads operands from an internal 32-entry register file.
- Consumes the execution unit's result/exception outputs one cycle later, writing back results and raising a sticky trap on exceptions or illegal encodings.
- Owns RAW hazard stalling, forwarding, and squash of the shadow instruction after a fault.

---
 rtl/decode_issue.sv | 183 ++++++++++++++++++
 tb/tb_decode_issue.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue.sv
// ============================================================================
// decode_issue : integer-pipe front end (decode, regfile read, hazards, trap)
// Revision     : 1.0  initial release
// ============================================================================
`default_nettype none
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ALEN
`define ALEN 32
`endif

module decode_issue (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  output logic              fetch_ready,
  input  logic [31:0]       fetch_instruction,
  input  logic [`ALEN-1:0]  fetch_instruction_addr,
  output logic [`ALEN-1:0]  decode_instruction_addr,
  output logic [4:0]        opcode,
  output logic [4:0]        rd,
  output logic [2:0]        funct3,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [`XLEN-1:0]  rs1_data,
  output logic [`XLEN-1:0]  rs2_data,
  output logic [6:0]        funct7,
  output logic [11:0]       i_imm,
  output logic [19:0]       u_imm,
  output logic              input_valid,
  output logic              input_is_int,
  input  logic              exec_int_output_valid,
  input  logic              exec_int_exception,
  input  logic [`XLEN-1:0]  exec_int_result,
  output logic              trap_valid,
  output logic [`ALEN-1:0]  trap_addr
);

  typedef enum logic [0:0] {S_RUN = 1'b0, S_TRAPPED = 1'b1} state_t;
  state_t r_state, w_state_next;

  logic [`XLEN-1:0] r_rf [32];

  logic [`ALEN-1:0] r_dec_addr, r_wb_addr, r_trap_addr;
  logic [4:0]       r_opcode, r_rd, r_rs1, r_rs2, r_iss_rd, r_wb_rd;
  logic [2:0]       r_funct3;
  logic [6:0]       r_funct7;
  logic [11:0]      r_i_imm;
  logic [19:0]      r_u_imm;
  logic [`XLEN-1:0] r_rs1_data, r_rs2_data;
  logic             r_input_valid, r_input_is_int, r_wb_pending, r_kill, r_trap_valid;

  logic [4:0]       w_rs1, w_rs2, w_rd;
  logic             w_stall, w_exec_trap, w_accept, w_illegal, w_issue;
  logic             w_fwd_ok, w_wb_en, w_ready;
  logic [`XLEN-1:0] w_rs1_data, w_rs2_data;

  assign w_rs1 = fetch_instruction[19:15];
  assign w_rs2 = fetch_instruction[24:20];
  assign w_rd  = fetch_instruction[11:7];

  // Only the bundle sitting in decode can be too young to forward from.
  assign w_stall = r_input_valid &&
                   (((w_rs1 != 5'd0) && (w_rs1 == r_iss_rd)) ||
                    ((w_rs2 != 5'd0) && (w_rs2 == r_iss_rd)));

  assign w_exec_trap = (r_state == S_RUN) && exec_int_output_valid &&
                       exec_int_exception && !r_kill;
  assign w_accept    = fetch_valid && w_ready;
  assign w_illegal   = (fetch_instruction[1:0] != 2'b11);
  assign w_issue     = w_accept && !w_illegal;

  assign w_fwd_ok = r_wb_pending && (r_wb_rd != 5'd0) &&
                    exec_int_output_valid && !exec_int_exception;
  assign w_wb_en  = (r_state == S_RUN) && r_wb_pending && exec_int_output_valid &&
                    !exec_int_exception && !r_kill && (r_wb_rd != 5'd0);

  assign w_rs1_data = (w_rs1 == 5'd0) ? '0 :
                      (w_fwd_ok && (w_rs1 == r_wb_rd)) ? exec_int_result : r_rf[w_rs1];
  assign w_rs2_data = (w_rs2 == 5'd0) ? '0 :
                      (w_fwd_ok && (w_rs2 == r_wb_rd)) ? exec_int_result : r_rf[w_rs2];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    case (r_state)
      S_RUN: begin
        w_ready = !w_stall && !w_exec_trap;
        if (w_exec_trap || (fetch_valid && w_ready && w_illegal))
          w_state_next = S_TRAPPED;
      end
      default: w_state_next = S_TRAPPED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (w_wb_en) begin
      r_rf[r_wb_rd] <= exec_int_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_input_valid  <= 1'b0;
      r_input_is_int <= 1'b0;
      r_dec_addr     <= '0;
      r_opcode       <= '0;
      r_rd           <= '0;
      r_funct3       <= '0;
      r_rs1          <= '0;
      r_rs2          <= '0;
      r_funct7       <= '0;
      r_i_imm        <= '0;
      r_u_imm        <= '0;
      r_rs1_data     <= '0;
      r_rs2_data     <= '0;
      r_iss_rd       <= '0;
      r_wb_rd        <= '0;
      r_wb_addr      <= '0;
      r_wb_pending   <= 1'b0;
      r_kill         <= 1'b0;
      r_trap_valid   <= 1'b0;
      r_trap_addr    <= '0;
    end else begin
      r_input_valid <= w_issue;
      if (w_issue) begin
        r_input_is_int <= 1'b1;
        r_dec_addr     <= fetch_instruction_addr;
        r_opcode       <= fetch_instruction[6:2];
        r_rd           <= w_rd;
        r_funct3       <= fetch_instruction[14:12];
        r_rs1          <= w_rs1;
        r_rs2          <= w_rs2;
        r_funct7       <= fetch_instruction[31:25];
        r_i_imm        <= fetch_instruction[31:20];
        r_u_imm        <= fetch_instruction[31:12];
        r_rs1_data     <= w_rs1_data;
        r_rs2_data     <= w_rs2_data;
        r_iss_rd       <= w_rd;
      end
      r_wb_rd      <= r_iss_rd;
      r_wb_addr    <= r_dec_addr;
      r_wb_pending <= r_input_valid;
      // The younger bundle already in decode must not retire after a fault.
      r_kill       <= w_exec_trap && r_input_valid;
      if (w_exec_trap) begin
        r_trap_valid <= 1'b1;
        r_trap_addr  <= r_wb_addr;
      end else if (w_accept && w_illegal) begin
        r_trap_valid <= 1'b1;
        r_trap_addr  <= fetch_instruction_addr;
      end
    end
  end

  assign fetch_ready             = w_ready;
  assign decode_instruction_addr = r_dec_addr;
  assign opcode                  = r_opcode;
  assign rd                      = r_rd;
  assign funct3                  = r_funct3;
  assign rs1                     = r_rs1;
  assign rs2                     = r_rs2;
  assign rs1_data                = r_rs1_data;
  assign rs2_data                = r_rs2_data;
  assign funct7                  = r_funct7;
  assign i_imm                   = r_i_imm;
  assign u_imm                   = r_u_imm;
  assign input_valid             = r_input_valid;
  assign input_is_int            = r_input_is_int;
  assign trap_valid              = r_trap_valid;
  assign trap_addr               = r_trap_addr;

endmodule

`default_nettype wire

// File: tb/tb_decode_issue.sv
// ============================================================================
// tb_decode_issue : directed self-checking bench for decode_issue
// Revision        : 1.0  initial release
// ============================================================================
`default_nettype none
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ALEN
`define ALEN 32
`endif

module tb_decode_issue;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              fetch_valid = 1'b0;
  logic              fetch_ready;
  logic [31:0]       fetch_instruction = '0;
  logic [`ALEN-1:0]  fetch_instruction_addr = '0;
  logic [`ALEN-1:0]  decode_instruction_addr;
  logic [4:0]        opcode, rd, rs1, rs2;
  logic [2:0]        funct3;
  logic [`XLEN-1:0]  rs1_data, rs2_data;
  logic [6:0]        funct7;
  logic [11:0]       i_imm;
  logic [19:0]       u_imm;
  logic              input_valid, input_is_int;
  logic              exec_int_output_valid = 1'b0;
  logic              exec_int_exception = 1'b0;
  logic [`XLEN-1:0]  exec_int_result = '0;
  logic              trap_valid;
  logic [`ALEN-1:0]  trap_addr;

  int n_tests = 0;
  int n_fail  = 0;

  decode_issue dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_instruction(fetch_instruction),
    .fetch_instruction_addr(fetch_instruction_addr),
    .decode_instruction_addr(decode_instruction_addr),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .funct7(funct7),
    .i_imm(i_imm), .u_imm(u_imm),
    .input_valid(input_valid), .input_is_int(input_is_int),
    .exec_int_output_valid(exec_int_output_valid),
    .exec_int_exception(exec_int_exception),
    .exec_int_result(exec_int_result),
    .trap_valid(trap_valid), .trap_addr(trap_addr)
  );

  always #5 clk = ~clk;

  // Minimal execution unit: captures the bundle, answers one cycle later.
  logic              cap_v = 1'b0;
  logic [4:0]        cap_op = '0;
  logic [2:0]        cap_f3 = '0;
  logic [11:0]       cap_i = '0;
  logic [19:0]       cap_u = '0;
  logic [`ALEN-1:0]  cap_a = '0;
  logic [`XLEN-1:0]  cap_1 = '0, cap_2 = '0;
  logic              exc_en = 1'b0;
  logic [`ALEN-1:0]  exc_addr = '0;

  always @(negedge clk) begin
    cap_v  = input_valid;
    cap_op = opcode;
    cap_f3 = funct3;
    cap_i  = i_imm;
    cap_u  = u_imm;
    cap_a  = decode_instruction_addr;
    cap_1  = rs1_data;
    cap_2  = rs2_data;
  end

  always @(posedge clk) begin
    #1;
    exec_int_output_valid = cap_v && !rst;
    exec_int_exception    = cap_v && exc_en && (cap_a == exc_addr);
    case (cap_op)
      5'b01101: exec_int_result = {cap_u, 12'h000};
      5'b00101: exec_int_result = cap_a + {cap_u, 12'h000};
      5'b00100: exec_int_result = cap_1 + {{20{cap_i[11]}}, cap_i};
      5'b01100: exec_int_result = cap_1 + cap_2;
      default:  exec_int_result = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [4:0] d, input logic [4:0] s1,
                                        input logic [11:0] imm);
    return {imm, s1, 3'b000, d, 7'h13};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] d, input logic [4:0] s1,
                                        input logic [4:0] s2);
    return {7'h00, s2, s1, 3'b000, d, 7'h33};
  endfunction

  // Called at posedge+1; returns at posedge+1 right after acceptance.
  task automatic send(input logic [31:0] ins, input logic [`ALEN-1:0] a, output int st);
    fetch_valid = 1'b1;
    fetch_instruction = ins;
    fetch_instruction_addr = a;
    st = 0;
    @(negedge clk);
    while (!fetch_ready && st < 20) begin
      st++;
      @(negedge clk);
    end
    if (st >= 20) chk("ready_timeout", 64'(fetch_ready), 64'd1);
    @(posedge clk);
    #1 fetch_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic to_issue_phase();
    @(posedge clk);
    #1;
  endtask

  int st, st2, st3, st4;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_input_valid", 64'(input_valid), 64'd0);
    chk("rst_input_is_int", 64'(input_is_int), 64'd0);
    chk("rst_trap_valid", 64'(trap_valid), 64'd0);
    chk("rst_trap_addr", 64'(trap_addr), 64'd0);
    chk("rst_fetch_ready", 64'(fetch_ready), 64'd1);
    chk("rst_opcode", 64'(opcode), 64'd0);
    to_issue_phase();

    // LUI x1,0x12345
    send(32'h123450B7, 'h100, st);
    @(negedge clk);
    chk("lui_stall", 64'(st), 64'd0);
    chk("lui_valid", 64'(input_valid), 64'd1);
    chk("lui_is_int", 64'(input_is_int), 64'd1);
    chk("lui_opcode", 64'(opcode), 64'h0D);
    chk("lui_rd", 64'(rd), 64'd1);
    chk("lui_uimm", 64'(u_imm), 64'h12345);
    chk("lui_addr", 64'(decode_instruction_addr), 64'h100);
    to_issue_phase();
    idle(3);
    send(enc_i(5'd0, 5'd1, 12'd0), 'h104, st);
    @(negedge clk);
    chk("read_x1", 64'(rs1_data), 64'h12345000);
    to_issue_phase();
    idle(3);

    // ADDI x2,x0,5 ; ADDI x3,x2,1 back to back
    send(enc_i(5'd2, 5'd0, 12'd5), 'h108, st);
    send(enc_i(5'd3, 5'd2, 12'd1), 'h10C, st2);
    @(negedge clk);
    chk("raw_stall_cycles", 64'(st2), 64'd1);
    chk("raw_fwd_rs1", 64'(rs1_data), 64'd5);
    chk("raw_rd", 64'(rd), 64'd3);
    chk("raw_iimm", 64'(i_imm), 64'd1);
    to_issue_phase();
    idle(3);

    // ADDI x4,x0,7 ; NOP ; NOP ; ADD x6,x4,x3
    send(enc_i(5'd4, 5'd0, 12'd7), 'h110, st);
    send(enc_i(5'd0, 5'd0, 12'd0), 'h114, st2);
    send(enc_i(5'd0, 5'd0, 12'd0), 'h118, st3);
    send(enc_r(5'd6, 5'd4, 5'd3), 'h11C, st4);
    @(negedge clk);
    chk("gap_stalls", 64'(st + st2 + st3 + st4), 64'd0);
    chk("gap_rs1_x4", 64'(rs1_data), 64'd7);
    chk("gap_rs2_x3", 64'(rs2_data), 64'd6);
    chk("gap_opcode", 64'(opcode), 64'h0C);
    to_issue_phase();
    idle(3);

    // ADDI x0,x0,9 must not write x0
    send(enc_i(5'd0, 5'd0, 12'd9), 'h120, st);
    to_issue_phase();
    idle(3);
    chk("x0_regfile", 64'(dut.r_rf[0]), 64'd0);
    send(enc_r(5'd0, 5'd0, 5'd6), 'h124, st);
    @(negedge clk);
    chk("x0_read", 64'(rs1_data), 64'd0);
    chk("x6_read", 64'(rs2_data), 64'd13);
    to_issue_phase();
    idle(3);

    // Illegal encoding traps
    send(32'h0000_0000, 'h200, st);
    @(negedge clk);
    chk("ill_trap_valid", 64'(trap_valid), 64'd1);
    chk("ill_trap_addr", 64'(trap_addr), 64'h200);
    chk("ill_input_valid", 64'(input_valid), 64'd0);
    chk("ill_ready", 64'(fetch_ready), 64'd0);
    to_issue_phase();
    @(negedge clk);
    chk("ill_ready_held", 64'(fetch_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst1_trap_valid", 64'(trap_valid), 64'd0);
    chk("rst1_ready", 64'(fetch_ready), 64'd1);
    to_issue_phase();
    send(enc_i(5'd0, 5'd1, 12'd0), 'h2E0, st);
    @(negedge clk);
    chk("rst1_x1_cleared", 64'(rs1_data), 64'd0);
    to_issue_phase();
    idle(2);

    // Exec exception at 0x300 with ADDI x5 at 0x304 in flight
    send(enc_i(5'd5, 5'd0, 12'd3), 'h2F0, st);
    idle(3);
    exc_addr = 'h300;
    exc_en   = 1'b1;
    send(enc_i(5'd7, 5'd0, 12'd1), 'h300, st);
    send(enc_i(5'd5, 5'd0, 12'd9), 'h304, st2);
    @(negedge clk);
    chk("exc_stalls", 64'(st + st2), 64'd0);
    chk("exc_ready_low", 64'(fetch_ready), 64'd0);
    to_issue_phase();
    @(negedge clk);
    chk("exc_trap_valid", 64'(trap_valid), 64'd1);
    chk("exc_trap_addr", 64'(trap_addr), 64'h300);
    chk("exc_input_valid", 64'(input_valid), 64'd0);
    to_issue_phase();
    idle(2);
    chk("exc_x5_kept", 64'(dut.r_rf[5]), 64'd3);
    chk("exc_trap_addr_held", 64'(trap_addr), 64'h300);
    exc_en = 1'b0;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_trap_valid", 64'(trap_valid), 64'd0);
    chk("rst2_ready", 64'(fetch_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
